// File: rtl/sm_result_stage.sv
// Two-stage result pipeline behind the sign-magnitude adder: converts the two's-complement sum
// to saturated sign-magnitude. Define SM_OVF_CNT_EN to include the saturating overflow counter.
module sm_result_stage #(
    parameter int unsigned DEPTH_STAGES = 2,
    parameter int unsigned SAT_MAG      = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [8:0] in_sum,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sm,
    output logic       out_cmp,
    output logic       out_ovf,
    output logic [7:0] ovf_cnt
);

    if (DEPTH_STAGES != 2) begin : gen_depth_check
        $error("sm_result_stage supports DEPTH_STAGES = 2 only");
    end

    localparam logic [8:0] SatMag9 = SAT_MAG[8:0];

    logic       s1_valid_q;
    logic [7:0] s1_a_q;
    logic [7:0] s1_b_q;
    logic [8:0] s1_sum_q;

    logic       s2_valid_q;
    logic [7:0] s2_sm_q;
    logic       s2_cmp_q;
    logic       s2_ovf_q;

    logic       s2_adv;
    logic       accept;

    logic       sa;
    logic       sb;
    logic [7:0] t;
    logic [8:0] mag9;
    logic [6:0] mag;
    logic       sign;
    logic       ovf;

    // Only the operand signs steer the conversion; magnitudes are carried for completeness.
    logic unused_mag;
    assign unused_mag = ^{s1_a_q[6:0], s1_b_q[6:0]};

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sa   = s1_a_q[7];
        sb   = s1_b_q[7];
        t    = s1_sum_q[7:0];
        mag9 = '0;
        sign = 1'b0;
        if (!sa && !sb) begin
            mag9 = {1'b0, t};
            sign = 1'b0;
        end else if (sa && sb) begin
            mag9 = {1'b0, ~t + 8'd1};
            sign = 1'b1;
        end else begin
            sign = t[7];
            mag9 = t[7] ? {1'b0, ~t + 8'd1} : {1'b0, t};
        end
        ovf = (mag9 > SatMag9);
        mag = ovf ? SatMag9[6:0] : mag9[6:0];
        // No negative zero, including after saturation to a zero SAT_MAG.
        if (mag == 7'd0) begin
            sign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sum_q   <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_sum_q   <= in_sum;
        end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sm_q    <= '0;
            s2_cmp_q   <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sm_q  <= {sign, mag};
                s2_cmp_q <= s1_sum_q[8];
                s2_ovf_q <= ovf;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sm    = s2_sm_q;
    assign out_cmp   = s2_cmp_q;
    assign out_ovf   = s2_ovf_q;

`ifdef SM_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (s2_valid_q && out_ready && s2_ovf_q && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_sm_result_stage.sv
// Self-checking bench for sm_result_stage: directed cases plus randomized streams against a
// value-level reference model (true signed sums, queue of expected results).
module tb_sm_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [8:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sm;
    logic       out_cmp;
    logic       out_ovf;
    logic [7:0] ovf_cnt;

    sm_result_stage #(
        .DEPTH_STAGES(2),
        .SAT_MAG     (127)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sum   (in_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sm   (out_sm),
        .out_cmp  (out_cmp),
        .out_ovf  (out_ovf),
        .ovf_cnt  (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];          // {cmp, ovf, sm}
    int         exp_cnt  = 0;
    logic       stalled_prev = 1'b0;
    logic [9:0] prev_out = '0;
    logic [9:0] last_res = '0;
    logic       smp_out_valid = 1'b0;
    logic       acc = 1'b0;

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int smval(input logic [7:0] x);
        return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    endfunction

    function automatic logic [7:0] twos(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = smval(a) + smval(b);
        return s[7:0];
    endfunction

    // Expected result straight from the true signed sum.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cmp);
        int   s;
        int   m;
        logic ov;
        logic sg;
        s  = smval(a) + smval(b);
        m  = (s < 0) ? -s : s;
        ov = (m > 127);
        if (ov) m = 127;
        sg = (s < 0) && (m != 0);
        return {cmp, ov, sg, m[6:0]};
    endfunction

    task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic cmp, input logic ordy);
        logic [9:0] e;
        logic [9:0] cur;
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_sum    = {cmp, twos(a, b)};
        out_ready = ordy;
        #1;
        cur = {out_cmp, out_ovf, out_sm};
        if (stalled_prev) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", cur, prev_out);
        end
        check("in_ready", in_ready, (exp_q.size() < 2) || ordy);
        check("ovf_cnt", ovf_cnt, exp_cnt);
        smp_out_valid = out_valid;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("result", cur, e);
                last_res = cur;
`ifdef SM_OVF_CNT_EN
                if (e[8] && exp_cnt < 255) exp_cnt++;
`endif
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model(a, b, cmp));
        stalled_prev = out_valid && !ordy;
        prev_out     = cur;
        @(posedge clk);
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        logic       pc;
        int         sent;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sum    = '0;
        out_ready = 1'b0;
        #23;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sm", out_sm, 8'h00);
        check("rst_out_cmp", out_cmp, 1'b0);
        check("rst_out_ovf", out_ovf, 1'b0);
        check("rst_ovf_cnt", ovf_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 + 3, latency of two edges after accept
        cycle(1'b1, 8'h05, 8'h03, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("lat_cycle1", smp_out_valid, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("lat_cycle2", smp_out_valid, 1'b1);
        check("sum_5p3", last_res, 10'h008);

        // -5 + 3
        cycle(1'b1, 8'h85, 8'h03, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("sum_m5p3", last_res, 10'h282);

        // Positive and negative overflow, back to back
        cycle(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("ovf_pos", last_res, 10'h17F);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("ovf_neg", last_res, 10'h1FF);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
`ifdef SM_OVF_CNT_EN
        check("ovf_cnt_two", ovf_cnt, 8'd2);
`else
        check("ovf_cnt_tied", ovf_cnt, 8'd0);
`endif

        // No negative zero
        cycle(1'b1, 8'h80, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h85, 8'h05, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("negzero_a", last_res[7:0], 8'h00);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("negzero_b", last_res[7:0], 8'h00);

        // Reset with two items in flight
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
        check("two_in_flight", exp_q.size(), 2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_ovf_cnt", ovf_cnt, 8'h00);
        exp_q.delete();
        exp_cnt      = 0;
        stalled_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            check("post_rst_idle", smp_out_valid, 1'b0);
        end

        // Eight back-to-back inputs, random out_ready with a forced 3-cycle stall
        sent = 0;
        pa   = 8'($urandom);
        pb   = 8'($urandom);
        pc   = 1'($urandom);
        for (int c = 0; c < 300 && (sent < 8 || exp_q.size() != 0); c++) begin
            cycle(sent < 8, pa, pb, pc, (c >= 3 && c < 6) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (acc) begin
                sent++;
                pa = 8'($urandom);
                pb = 8'($urandom);
                pc = 1'($urandom);
            end
        end
        check("burst8_drained", exp_q.size() + (8 - sent), 0);

        // Longer random stream with random valid and ready
        sent = 0;
        for (int c = 0; c < 3000 && (sent < 300 || exp_q.size() != 0); c++) begin
            cycle((sent < 300) && ($urandom_range(0, 3) != 0), pa, pb, pc,
                  ($urandom_range(0, 2) != 0));
            if (acc) begin
                sent++;
                pa = 8'($urandom);
                pb = 8'($urandom);
                pc = 1'($urandom);
            end
        end
        check("stream_drained", exp_q.size() + (300 - sent), 0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_result_stage.md
Name: sm_result_stage

Overview:
- Pipelined stage that sits directly downstream of the 8-bit sign-magnitude adder.
- Consumes the adder's 9-bit result {cmp, twos[7:0]} together with the two sign-magnitude operands that produced it.
- Converts the two's-complement sum back to 8-bit sign-magnitude form, saturating and flagging overflow.
- Results pass to the next consumer through a valid/ready handshake.

Parameters:
- DEPTH_STAGES, 2, pipeline register stages from accept to output; fixed at 2, other values unsupported.
- SAT_MAG, 127, magnitude substituted on overflow.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a result
- in_ready  output  1  stage can accept this cycle
- in_a  input  8  operand A, sign-magnitude (bit7 sign, [6:0] magnitude)
- in_b  input  8  operand B, sign-magnitude
- in_sum  input  9  adder output: [8] comparator bit, [7:0] two's-complement sum of the signed magnitudes
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_sm  output  8  result, sign-magnitude
- out_cmp  output  1  in_sum[8] passed through, aligned with out_sm
- out_ovf  output  1  true magnitude exceeded SAT_MAG
- ovf_cnt  output  8  overflow counter (only with SM_OVF_CNT_EN; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0): both stage valid bits 0, out_valid=0, out_sm=0, out_cmp=0, out_ovf=0, ovf_cnt=0.
- All data registers clear on reset.
- Reset asserted mid-operation discards all in-flight results; no partial output after release.
- Handshake:
  - Transfer occurs on a clk edge where valid && ready.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational path from out_ready permitted).
  - out_valid and out_* stay stable while out_valid && !out_ready.
- Stage 1 registers in_a, in_b, in_sum on accept.
- Stage 2 computes and registers the result when empty or emptying.
- Latency: 2 cycles from input accept to out_valid, with out_ready held high.
- Throughput: 1 result per cycle.
- No result is dropped or duplicated under any out_ready pattern.
- Stage 2 arithmetic (sa=a[7], sb=b[7], t=twos[7:0]):
  - sa=0, sb=0: mag9 = {1'b0, t} unsigned; sign = 0.
  - sa=1, sb=1: mag9 = (256 - t) mod 256 as unsigned; sign = 1.
  - sa != sb: sign = t[7]; mag9 = t[7] ? -t : t (range 0..127).
  - mag9 > SAT_MAG: out_ovf = 1, magnitude = SAT_MAG. Otherwise out_ovf = 0.
  - Magnitude 0: sign forced 0 (no negative zero). Covers +0 + -0 and x + -x.
  - out_sm = {sign, magnitude[6:0]}.
- Boundaries:
  - 127 + 127 -> t = 0xFE, ovf, out_sm = 0x7F.
  - -127 + -127 -> out_sm = 0xFF, ovf.
  - Simultaneous accept and emit: both take effect in the same cycle.

Optional Feature:
- Macro SM_OVF_CNT_EN.
- Defined:
  - ovf_cnt increments by 1 on every output transfer with out_ovf = 1.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: no counter logic; ovf_cnt is constant 0.

Test Plan:
- Reset mid-stream: two items in flight, pulse rst_n low -> out_valid = 0 immediately; no output after release until new input.
- a=0x05, b=0x03, sum=0x008, out_ready=1 -> 2 cycles later out_sm=0x08, out_ovf=0, out_cmp=0.
- a=0x85 (-5), b=0x03, sum=0x1FE -> out_sm=0x82, out_cmp=1, out_ovf=0.
- a=0x7F, b=0x7F, sum=0x0FE; then a=0xFF, b=0xFF, sum=0x002 -> out_sm=0x7F then 0xFF, out_ovf=1 both. With SM_OVF_CNT_EN, ovf_cnt=2.
- a=0x80, b=0x00 and a=0x85, b=0x05 -> out_sm=0x00 both (no negative zero).
- Back-to-back 8 inputs with out_ready toggled randomly (including 3-cycle stall) -> all 8 results emitted in order; in_ready=0 only while both stages are full and out_ready=0.
